// File: rtl/pipeline_hazard_ctrl_if.sv
// Hazard-controller signal bundle for the five-stage pipeline.
// Groups the ID/EX/MEM/WB register identifiers, write enables, the branch
// redirect, the fetch-ready handshake and every controller output.
//   master : pipeline side (drives identifiers/handshake, reads controls)
//   slave  : hazard controller (reads identifiers/handshake, drives controls)
interface pipeline_hazard_ctrl_if #(
    parameter int CNT_W = 16
);
    logic [4:0]       rs1D;
    logic [4:0]       rs2D;
    logic [4:0]       rs1E;
    logic [4:0]       rs2E;
    logic [4:0]       rdE;
    logic             loadE;
    logic [4:0]       rdM;
    logic             regwriteM;
    logic [4:0]       rdW;
    logic             regwriteW;
    logic             pcsrcE;
    logic             imem_ready;
    logic             stallF;
    logic             stallD;
    logic             flushD;
    logic             flushE;
    logic [1:0]       forwardAE;
    logic [1:0]       forwardBE;
    logic [1:0]       fsm_state;
    logic [CNT_W-1:0] stall_cnt;
    logic [CNT_W-1:0] redirect_cnt;

    modport master (
        output rs1D, rs2D, rs1E, rs2E, rdE, loadE, rdM, regwriteM,
               rdW, regwriteW, pcsrcE, imem_ready,
        input  stallF, stallD, flushD, flushE, forwardAE, forwardBE,
               fsm_state, stall_cnt, redirect_cnt
    );

    modport slave (
        input  rs1D, rs2D, rs1E, rs2E, rdE, loadE, rdM, regwriteM,
               rdW, regwriteW, pcsrcE, imem_ready,
        output stallF, stallD, flushD, flushE, forwardAE, forwardBE,
               fsm_state, stall_cnt, redirect_cnt
    );
endinterface

// File: rtl/pipeline_hazard_ctrl.sv
// Hazard and fetch-sequencing controller for the five-stage pipeline.
// Produces IF/ID and ID/EX stall/flush controls, EX operand forwarding
// selects, tracks multi-cycle instruction fetches (RUN / WAIT / WAIT_KILL)
// and keeps saturating stall-cycle and redirect counters.
// Ports:
//   clk   : pipeline clock
//   reset : asynchronous, active-high reset
//   hz    : slave side of pipeline_hazard_ctrl_if (all pipeline signals)
module pipeline_hazard_ctrl #(
    parameter int CNT_W = 16
) (
    input  logic                    clk,
    input  logic                    reset,
    pipeline_hazard_ctrl_if.slave   hz
);
    typedef enum logic [1:0] {
        ST_RUN       = 2'b00,
        ST_WAIT      = 2'b01,
        ST_WAIT_KILL = 2'b10,
        ST_UNUSED    = 2'b11
    } state_e;

    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    state_e           state_q;
    state_e           state_d;
    logic [CNT_W-1:0] stall_cnt_q;
    logic [CNT_W-1:0] stall_cnt_d;
    logic [CNT_W-1:0] redirect_cnt_q;
    logic [CNT_W-1:0] redirect_cnt_d;

    logic             lwstall_s;
    logic             redirect_s;
    logic             stall_f_s;
    logic             stall_d_s;
    logic             flush_d_s;
    logic             flush_e_s;
    logic [1:0]       fwd_a_s;
    logic [1:0]       fwd_b_s;

    // MEM result is younger than WB, so it wins on a double match; x0 never forwards.
    function automatic logic [1:0] fwd_sel(
        input logic [4:0] rs,
        input logic [4:0] rd_m,
        input logic       we_m,
        input logic [4:0] rd_w,
        input logic       we_w
    );
        logic [1:0] sel;
        if (we_m && (rd_m != 5'd0) && (rd_m == rs)) begin
            sel = 2'b10;
        end else if (we_w && (rd_w != 5'd0) && (rd_w == rs)) begin
            sel = 2'b01;
        end else begin
            sel = 2'b00;
        end
        return sel;
    endfunction

    // Load-use detection and operand forwarding selects (forced to 00 during reset).
    always_comb begin
        lwstall_s = hz.loadE && (hz.rdE != 5'd0) &&
                    ((hz.rdE == hz.rs1D) || (hz.rdE == hz.rs2D));
        if (reset) begin
            fwd_a_s = 2'b00;
            fwd_b_s = 2'b00;
        end else begin
            fwd_a_s = fwd_sel(hz.rs1E, hz.rdM, hz.regwriteM, hz.rdW, hz.regwriteW);
            fwd_b_s = fwd_sel(hz.rs2E, hz.rdM, hz.regwriteM, hz.rdW, hz.regwriteW);
        end
    end

    // Fetch FSM next-state and stall/flush decode.
    always_comb begin
        state_d    = state_q;
        stall_f_s  = 1'b0;
        stall_d_s  = 1'b0;
        flush_d_s  = 1'b0;
        flush_e_s  = 1'b0;
        redirect_s = 1'b0;
        if (reset) begin
            state_d = ST_RUN;
        end else begin
            case (state_q)
                ST_WAIT: begin
                    // ID already holds a NOP here, so load-use cannot occur.
                    if (hz.pcsrcE) begin
                        flush_d_s  = 1'b1;
                        flush_e_s  = 1'b1;
                        redirect_s = 1'b1;
                        // A response arriving with the redirect is wrong-path and is
                        // discarded by flushD; otherwise it must still be drained.
                        state_d    = hz.imem_ready ? ST_RUN : ST_WAIT_KILL;
                    end else if (hz.imem_ready) begin
                        state_d = ST_RUN;
                    end else begin
                        stall_f_s = 1'b1;
                        flush_d_s = 1'b1;
                        state_d   = ST_WAIT;
                    end
                end
                ST_WAIT_KILL: begin
                    // PC already holds the target; just drop the stale response.
                    stall_f_s = 1'b1;
                    flush_d_s = 1'b1;
                    state_d   = hz.imem_ready ? ST_RUN : ST_WAIT_KILL;
                end
                default: begin
                    // ST_RUN and the unreachable encoding behave identically.
                    if (hz.pcsrcE) begin
                        flush_d_s  = 1'b1;
                        flush_e_s  = 1'b1;
                        redirect_s = 1'b1;
                        state_d    = hz.imem_ready ? ST_RUN : ST_WAIT_KILL;
                    end else if (lwstall_s) begin
                        // Fetched instruction stays on the bus, so the fetch state is kept.
                        stall_f_s = 1'b1;
                        stall_d_s = 1'b1;
                        flush_e_s = 1'b1;
                        state_d   = ST_RUN;
                    end else if (!hz.imem_ready) begin
                        stall_f_s = 1'b1;
                        flush_d_s = 1'b1;
                        state_d   = ST_WAIT;
                    end else begin
                        state_d = ST_RUN;
                    end
                end
            endcase
        end
    end

    // Saturating performance counter next values.
    always_comb begin
        if (stall_f_s && (stall_cnt_q != CNT_MAX)) begin
            stall_cnt_d = stall_cnt_q + CNT_ONE;
        end else begin
            stall_cnt_d = stall_cnt_q;
        end
        if (redirect_s && (redirect_cnt_q != CNT_MAX)) begin
            redirect_cnt_d = redirect_cnt_q + CNT_ONE;
        end else begin
            redirect_cnt_d = redirect_cnt_q;
        end
    end

    // State and counter registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q        <= ST_RUN;
            stall_cnt_q    <= {CNT_W{1'b0}};
            redirect_cnt_q <= {CNT_W{1'b0}};
        end else begin
            state_q        <= state_d;
            stall_cnt_q    <= stall_cnt_d;
            redirect_cnt_q <= redirect_cnt_d;
        end
    end

    assign hz.stallF       = stall_f_s;
    assign hz.stallD       = stall_d_s;
    assign hz.flushD       = flush_d_s;
    assign hz.flushE       = flush_e_s;
    assign hz.forwardAE    = fwd_a_s;
    assign hz.forwardBE    = fwd_b_s;
    assign hz.fsm_state    = state_q;
    assign hz.stall_cnt    = stall_cnt_q;
    assign hz.redirect_cnt = redirect_cnt_q;
endmodule

// File: doc/pipeline_hazard_ctrl.md
# pipeline_hazard_ctrl

Hazard and fetch-sequencing controller for the five-stage RISC-V pipeline. Drives stall/flush controls for the IF/ID and ID/EX pipeline registers. Generates EX-stage operand forwarding selects. Runs a small FSM that tracks multi-cycle instruction-memory fetches, including redirects that arrive while a fetch is outstanding. Keeps saturating performance counters for stall cycles and taken redirects.

## Interface
Parameters:
- CNT_W, 16, width of both performance counters

Ports:
- clk  in  1  pipeline clock
- reset  in  1  asynchronous, active-high reset
- rs1D, rs2D  in  5 each  source registers of the instruction in ID
- rs1E, rs2E  in  5 each  source registers of the instruction in EX
- rdE  in  5  destination register in EX
- loadE  in  1  instruction in EX is a load
- rdM  in  5  destination register in MEM
- regwriteM  in  1  MEM writes the register file
- rdW  in  5  destination register in WB
- regwriteW  in  1  WB writes the register file
- pcsrcE  in  1  taken branch/jump resolved in EX (PC redirect)
- imem_ready  in  1  fetch bus holds a valid instruction for the outstanding request this cycle
- stallF  out  1  hold PC
- stallD  out  1  hold IF/ID register
- flushD  out  1  load NOP into IF/ID (the IF/ID register gives flush priority over stall)
- flushE  out  1  load NOP into ID/EX
- forwardAE, forwardBE  out  2 each  EX operand select: 00 register file, 01 WB result, 10 MEM ALU result
- fsm_state  out  2  00 RUN, 01 WAIT, 10 WAIT_KILL
- stall_cnt  out  CNT_W  cycles with stallF=1
- redirect_cnt  out  CNT_W  honored pcsrcE cycles

## Operation
- lwstall = loadE & (rdE != 0) & (rdE == rs1D | rdE == rs2D).
- forwardAE:
  - 10 if regwriteM & rdM != 0 & rdM == rs1E.
  - else 01 if regwriteW & rdW != 0 & rdW == rs1E.
  - else 00.
  - forwardBE is identical using rs2E.
  - MEM wins over WB on a double match.
- Defaults for every output rule below: stallF/stallD/flushD/flushE = 0 unless listed.
- RUN, in priority order:
  - pcsrcE: flushD=1, flushE=1. Next state is WAIT_KILL if imem_ready=0, else RUN. lwstall is ignored.
  - lwstall: stallF=1, stallD=1, flushE=1, flushD=0. Stay in RUN. The fetched instruction stays on the bus.
  - imem_ready=0: stallF=1, flushD=1. Next state WAIT.
  - Otherwise: all 0.
- WAIT (ID holds a NOP, so lwstall is ignored here):
  - pcsrcE: flushD=1, flushE=1, stallF=0. Next state is RUN if imem_ready=1 (the response is discarded by flushD), else WAIT_KILL.
  - imem_ready=1: all 0. The instruction latches into ID. Next state RUN.
  - Otherwise: stallF=1, flushD=1.
- WAIT_KILL: stallF=1, flushD=1 every cycle; pcsrcE and lwstall are ignored. On imem_ready=1 the wrong-path response is dropped and next state is RUN; the PC already holds the target.
- fsm_state 11 is unreachable and decodes as RUN.
- Counters:
  - stall_cnt increments on every cycle with stallF=1.
  - redirect_cnt increments on every cycle pcsrcE is honored (RUN or WAIT).
  - Both saturate at all-ones and never wrap.

## Timing
- All control and forwarding outputs are combinational from the current state and inputs, valid in the same cycle. The state and counters are registered on posedge clk.
- Reset asserted, any time including mid-fetch:
  - state = RUN, stall_cnt = 0, redirect_cnt = 0 immediately.
  - While reset is high, stallF/stallD/flushD/flushE = 0 and forwardAE/forwardBE = 00.
- First edge after reset deasserts: normal RUN evaluation.
- Load-use penalty: exactly one bubble per lwstall, since the load leaves EX after one cycle.
- Redirect penalty in RUN with imem_ready=1: two flushed instructions (ID and EX), zero extra stall.
- Redirect during an outstanding fetch: WAIT_KILL lasts until the stale response arrives, then one RUN cycle issues the target fetch.

## Test plan
- Forwarding:
  - rdM=5, regwriteM=1, rdW=5, regwriteW=1, rs1E=5 -> forwardAE=10.
  - rdM=0, regwriteM=1, rdW=5, regwriteW=1, rs1E=5 -> forwardAE=01.
  - rs2E=0 with matching rdW -> forwardBE=00.
- Load-use: loadE=1, rdE=7, rs2D=7, RUN, imem_ready=1 -> stallF=stallD=flushE=1 and flushD=0 for one cycle; stall_cnt=1.
- Slow fetch: imem_ready low for 3 cycles then high -> fsm_state RUN, WAIT, WAIT, WAIT, RUN. stallF=flushD=1 on the 3 low cycles; all 0 on the ready cycle; stall_cnt=3.
- Redirect mid-fetch: in WAIT, pcsrcE=1 with imem_ready=0 -> flushD=flushE=1, stallF=0, next WAIT_KILL, redirect_cnt=1. With imem_ready low 2 more cycles then high -> stallF=flushD=1 on all 3 of those cycles, then RUN.
- Priority: in RUN, pcsrcE=1 and lwstall=1 together -> stallD=0, flushD=flushE=1.
- Saturation and reset: CNT_W=4, hold imem_ready=0 for 20 cycles -> stall_cnt stops at 15. Assert reset asynchronously mid-WAIT -> fsm_state=00 and both counters 0 before the next edge.
